// File: rtl/track_sensor_conditioner.sv
// Track-occupancy sensor front end: per channel 2-flop sync, debounce,
// edge pulses and a sticky stuck-high fault flag. One lane instance per channel.

module tsc_lane #(
  parameter int DB_CYCLES    = 4,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic sr_o,
  output logic rise_o,
  output logic fall_o,
  output logic fault_o
);
  // Keep at least one bit so DB_CYCLES=1 still elaborates.
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int SW = $clog2(STUCK_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);
  localparam logic [SW-1:0] SC_MAX = SW'(STUCK_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          sr_q, sr_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          fault_q, fault_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [SW-1:0] sc_q, sc_d;

  always_comb begin
    sr_d    = sr_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    dc_d    = '0;
    sc_d    = '0;
    fault_d = fault_q;
    if (s2_q != sr_q) begin
      if (dc_q == DB_MAX) begin
        sr_d   = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        dc_d = dc_q + DW'(1);
      end
    end
    // Stuck counter follows the registered level, saturating at the limit.
    if (sr_q) begin
      if (sc_q == SC_MAX) begin
        sc_d    = sc_q;
        fault_d = 1'b1;
      end else begin
        sc_d = sc_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      sr_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      fault_q <= 1'b0;
      dc_q    <= '0;
      sc_q    <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      sr_q    <= sr_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      fault_q <= fault_d;
      dc_q    <= dc_d;
      sc_q    <= sc_d;
    end
  end

  assign sr_o    = sr_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign fault_o = fault_q;
endmodule

module track_sensor_conditioner #(
  parameter int N            = 4,
  parameter int DB_CYCLES    = 4,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic         Clock,
  input  logic         RESET,
  input  logic [N:1]   RAW,
  output logic [N:1]   SR,
  output logic [N:1]   RISE,
  output logic [N:1]   FALL,
  output logic [N:1]   FAULT
);
  for (genvar g = 1; g <= N; g++) begin : g_lane
    tsc_lane #(
      .DB_CYCLES    (DB_CYCLES),
      .STUCK_CYCLES (STUCK_CYCLES)
    ) u_lane (
      .clk_i   (Clock),
      .rst_ni  (RESET),
      .raw_i   (RAW[g]),
      .sr_o    (SR[g]),
      .rise_o  (RISE[g]),
      .fall_o  (FALL[g]),
      .fault_o (FAULT[g])
    );
  end
endmodule

// File: tb/tb_track_sensor_conditioner.sv
// Directed bench for track_sensor_conditioner with an edge-history reference
// model checked every cycle, plus literal checkpoints at the key edges.

module tb_track_sensor_conditioner;
  localparam int N     = 4;
  localparam int DB    = 4;
  localparam int STUCK = 16;
  localparam int HL    = 64;

  logic         Clock;
  logic         RESET;
  logic [N:1]   RAW;
  logic [N:1]   SR, RISE, FALL, FAULT;

  int n_chk  = 0;
  int n_fail = 0;

  track_sensor_conditioner #(
    .N(N), .DB_CYCLES(DB), .STUCK_CYCLES(STUCK)
  ) dut (
    .Clock (Clock),
    .RESET (RESET),
    .RAW   (RAW),
    .SR    (SR),
    .RISE  (RISE),
    .FALL  (FALL),
    .FAULT (FAULT)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string nm, input logic [N:1] act, input logic [N:1] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Reference model: keeps a trace of the resynchronized samples and applies the
  // rule "level flips once the last DB samples since the previous flip all differ".
  logic [N:1] m_s1, m_s2, m_sr, m_rise, m_fall, m_fault;
  logic [N:1] s2_tr [0:HL-1];
  int         last_chg [1:N];
  int         rose_at  [1:N];
  int         edge_n  = 0;
  bit         started = 1'b0;

  initial begin
    m_s1 = '0; m_s2 = '0; m_sr = '0; m_rise = '0; m_fall = '0; m_fault = '0;
    for (int i = 1; i <= N; i++) begin
      last_chg[i] = 0;
      rose_at[i]  = 0;
    end
    forever begin
      @(posedge Clock);
      edge_n++;
      if (!RESET) begin
        m_s1 = '0; m_s2 = '0; m_sr = '0; m_rise = '0; m_fall = '0; m_fault = '0;
        for (int i = 1; i <= N; i++) last_chg[i] = edge_n;
      end else begin
        s2_tr[edge_n % HL] = m_s2;
        m_rise = '0;
        m_fall = '0;
        for (int i = 1; i <= N; i++) begin
          if (m_sr[i] && (edge_n - rose_at[i] >= STUCK)) m_fault[i] = 1'b1;
          if (edge_n - last_chg[i] >= DB) begin
            bit all_dis;
            all_dis = 1'b1;
            for (int j = 0; j < DB; j++)
              if (s2_tr[(edge_n - j) % HL][i] == m_sr[i]) all_dis = 1'b0;
            if (all_dis) begin
              m_sr[i]     = ~m_sr[i];
              m_rise[i]   = m_sr[i];
              m_fall[i]   = ~m_sr[i];
              last_chg[i] = edge_n;
              if (m_sr[i]) rose_at[i] = edge_n;
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = RAW;
      end
      started = 1'b1;
    end
  end

  int rise_cnt [1:N];
  int fall_cnt [1:N];

  initial begin
    for (int i = 1; i <= N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    forever begin
      @(negedge Clock);
      if (started) begin
        chk("model_SR",    SR,    m_sr);
        chk("model_RISE",  RISE,  m_rise);
        chk("model_FALL",  FALL,  m_fall);
        chk("model_FAULT", FAULT, m_fault);
        if ((RISE & FALL) != '0) chk("rise_fall_excl", RISE & FALL, '0);
        for (int i = 1; i <= N; i++) begin
          if (RISE[i]) rise_cnt[i]++;
          if (FALL[i]) fall_cnt[i]++;
        end
      end
    end
  end

  initial begin
    int r0, f0;
    RESET = 1'b0;
    RAW   = 4'b1111;

    // Reset with all sensors high, then release.
    tick(3);
    chk("rst_SR",    SR,    4'b0000);
    chk("rst_RISE",  RISE,  4'b0000);
    chk("rst_FALL",  FALL,  4'b0000);
    chk("rst_FAULT", FAULT, 4'b0000);
    RESET = 1'b1;
    tick(5);
    chk("rel_SR_r4", SR, 4'b0000);
    tick(1);
    chk("rel_SR_r5",   SR,   4'b1111);
    chk("rel_RISE_r5", RISE, 4'b1111);
    tick(1);
    chk("rel_RISE_r6", RISE, 4'b0000);

    // All drop together.
    RAW = 4'b0000;
    tick(5);
    chk("drop_SR_k4", SR, 4'b1111);
    tick(1);
    chk("drop_SR_k5",   SR,   4'b0000);
    chk("drop_FALL_k5", FALL, 4'b1111);
    tick(5);

    // Glitch of 3 edges on channel 1 is rejected.
    r0 = rise_cnt[1];
    RAW = 4'b0001;
    tick(3);
    RAW = 4'b0000;
    tick(10);
    chk("glitch3_SR", SR, 4'b0000);
    chk("glitch3_rises", 4'(rise_cnt[1] - r0), 4'd0);

    // 4-edge pulse is accepted.
    r0 = rise_cnt[1];
    RAW = 4'b0001;
    tick(4);
    RAW = 4'b0000;
    tick(2);
    chk("pulse4_SR",   SR,   4'b0001);
    chk("pulse4_RISE", RISE, 4'b0001);
    tick(1);
    chk("pulse4_RISE_off", RISE, 4'b0000);
    tick(10);
    chk("pulse4_rises", 4'(rise_cnt[1] - r0), 4'd1);

    // Chatter on channel 2, then stable high.
    r0 = rise_cnt[2];
    f0 = fall_cnt[2];
    for (int t = 0; t < 20; t++) begin
      RAW[2] = ~RAW[2];
      tick(1);
    end
    RAW[2] = 1'b1;
    tick(5);
    chk("chat_SR_k4", SR, 4'b0000);
    tick(1);
    chk("chat_SR_k5",   SR,   4'b0010);
    chk("chat_RISE_k5", RISE, 4'b0010);
    tick(2);
    chk("chat_rises", 4'(rise_cnt[2] - r0), 4'd1);
    chk("chat_falls", 4'(fall_cnt[2] - f0), 4'd0);
    RAW = 4'b0000;
    tick(10);

    // Channel 3 rises while channel 4 falls.
    RAW = 4'b1000;
    tick(7);
    chk("sim_pre_SR", SR, 4'b1000);
    RAW = 4'b0100;
    tick(5);
    chk("sim_SR_k4", SR, 4'b1000);
    tick(1);
    chk("sim_SR",   SR,   4'b0100);
    chk("sim_RISE", RISE, 4'b0100);
    chk("sim_FALL", FALL, 4'b1000);
    RAW = 4'b0000;
    tick(8);

    // Stuck-high fault on channel 1.
    RAW = 4'b0001;
    tick(6);
    chk("stk_SR_e", SR, 4'b0001);
    tick(15);
    chk("stk_FAULT_e15", FAULT, 4'b0000);
    tick(1);
    chk("stk_FAULT_e16", FAULT, 4'b0001);
    RAW = 4'b0000;
    tick(8);
    chk("stk_SR_drop",     SR,    4'b0000);
    chk("stk_FAULT_stays", FAULT, 4'b0001);

    // 15-cycle high period on channel 2 must not fault.
    RAW = 4'b0010;
    tick(15);
    RAW = 4'b0000;
    tick(10);
    chk("stk15_FAULT", FAULT, 4'b0001);
    RESET = 1'b0;
    tick(1);
    chk("stk_FAULT_rst", FAULT, 4'b0000);
    RESET = 1'b1;
    tick(2);

    // Reset in the middle of a debounce run on channel 2.
    RAW = 4'b0010;
    tick(3);
    RESET = 1'b0;
    tick(1);
    RESET = 1'b1;
    tick(5);
    chk("mid_SR_r4", SR, 4'b0000);
    tick(1);
    chk("mid_SR_r5",   SR,   4'b0010);
    chk("mid_RISE_r5", RISE, 4'b0010);
    RESET = 1'b0;
    tick(1);
    chk("mid_RISE_rst", RISE, 4'b0000);
    chk("mid_SR_rst",   SR,   4'b0000);
    RESET = 1'b1;
    RAW   = 4'b0000;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
